instruction_decode: RTL
=======================

Name: instruction_decode

Overview:
- Producer side of the operand-fetch interface.
- Consumes the instruction-memory word stream (16-bit words) and assembles variable-length instructions of 1–3 words.
- Presents opcode, mode1, op1, mode2 and op2 as one registered bundle to the operand fetch stage, with valid/ready handshakes on both sides.
- Supports pipeline flush on branch redirect.

Parameters:
- OP_W, 16: operand width; equals the instruction word width. Only 16 is supported.
- COUNT_W, 16: width of the emitted-instruction counter.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous; discards any in-progress or pending instruction.
- in_valid  input  1  in_word is valid.
- in_word  input  16  instruction memory word.
- in_ready  output  1  decoder accepts in_word this cycle.
- out_valid  output  1  decoded bundle valid.
- out_ready  input  1  operand fetch stage accepts the bundle.
- opcode  output  8  decoded opcode.
- mode1  output  2  operand 1 addressing mode.
- op1  output  16  operand 1 extension word.
- mode2  output  2  operand 2 addressing mode.
- op2  output  16  operand 2 extension word.
- instr_count  output  COUNT_W  number of bundles handed off.

Behaviour:
- Word transfer occurs when in_valid && in_ready. Bundle transfer occurs when out_valid && out_ready.
- Header word layout:
  - opcode = [15:8]
  - mode1 = [7:6]
  - mode2 = [5:4]
  - [3:0] reserved, ignored
- Modes 2'b01, 2'b10 and 2'b11 each consume one extension word. Mode 2'b00 means no operand: that field is forced to 16'h0000 and consumes no word.
- Extension word order: op1 first, then op2.
- States:
  - S_HDR: in_ready=1, out_valid=0. On header accept, latch opcode/modes and clear op1/op2. Next state: S_OP1 if mode1≠0; else S_OP2 if mode2≠0; else S_OUT.
  - S_OP1: in_ready=1. On accept, op1<=in_word. Next state: S_OP2 if mode2≠0, else S_OUT.
  - S_OP2: in_ready=1. On accept, op2<=in_word, then go to S_OUT.
  - S_OUT: out_valid=1, in_ready=out_ready.
    - On bundle transfer, instr_count increments by 1 (wraps modulo 2^COUNT_W).
    - If a header is accepted in the same cycle, decode it exactly as in S_HDR (state may stay S_OUT). Otherwise go to S_HDR.
    - Without transfer, all outputs hold stable and no words are accepted.
- Latency: out_valid rises the cycle after the last word of the instruction is accepted. Single-word instructions sustain one bundle per cycle when out_ready=1.
- flush:
  - Next cycle: state=S_HDR, out_valid=0. Opcode/mode/op fields are not required to clear. instr_count is unchanged.
  - A word presented during the flush cycle is not accepted: in_ready=0 while flush=1.
  - A bundle transfer in the flush cycle still counts.
- rst (highest priority, including mid-instruction):
  - Next cycle: state=S_HDR; out_valid, opcode, mode1, op1, mode2, op2 and instr_count all 0.
  - in_ready=0 while rst=1.
- Outputs are registered. in_ready is a combinational function of state, out_ready, flush and rst only; no combinational path from in_valid.
- in_valid may drop between words of one instruction; assembly simply waits.

Test Plan:
1. Single-word instruction: rst, then 0x1200 with out_ready=1 -> next cycle out_valid=1, opcode=0x12, modes 0/0, op1=op2=0x0000; instr_count=1 after transfer.
2. Three-word instruction: 0x3490, 0xBEEF, 0x0005 -> one bundle with opcode=0x34, mode1=2, op1=0xBEEF, mode2=1, op2=0x0005. out_valid stays low until the cycle after 0x0005 is accepted.
3. mode1=0 skip: 0x4430, 0x0100 -> op1=0x0000, mode2=3, op2=0x0100 after two words.
4. Back-pressure, then full throughput:
   - Hold out_ready=0 for 3 cycles with 0x1200 pending -> bundle stable, in_ready=0.
   - Then out_ready=1 with 0x2100, 0x2200, 0x2300 streamed every cycle -> three consecutive bundles on consecutive cycles.
5. Flush mid-instruction: 0x3490, 0xBEEF, then flush=1, then 0x5500 -> no bundle for opcode 0x34; next bundle is opcode 0x55; instr_count unchanged by the flush.
6. Reset and counter wrap:
   - rst asserted after 0x3490 -> all outputs 0, then 0x1200 decodes normally.
   - With COUNT_W=4, 16 transfers -> instr_count returns to 0.

Source files
------------

// File: rtl/instruction_decode.sv
// Instruction decoder: assembles 1-3 word variable-length instructions from the
// instruction-memory word stream and hands one registered bundle per instruction
// to the operand fetch stage over a valid/ready handshake.
module instruction_decode #(
    parameter int unsigned OP_W    = 16,
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [OP_W-1:0]    in_word,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         opcode,
    output logic [1:0]         mode1,
    output logic [OP_W-1:0]    op1,
    output logic [1:0]         mode2,
    output logic [OP_W-1:0]    op2,
    output logic [COUNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        StHdr,
        StOp1,
        StOp2,
        StOut
    } state_e;

    state_e              state_q, state_d;
    logic                out_valid_q, out_valid_d;
    logic [7:0]          opcode_q, opcode_d;
    logic [1:0]          mode1_q, mode1_d;
    logic [1:0]          mode2_q, mode2_d;
    logic [OP_W-1:0]     op1_q, op1_d;
    logic [OP_W-1:0]     op2_q, op2_d;
    logic [COUNT_W-1:0]  count_q, count_d;

    logic accept;
    logic xfer;

    // Words are taken in every assembly state; while a bundle is held only when it leaves.
    always_comb begin
        in_ready = 1'b0;
        if (!rst && !flush) begin
            in_ready = (state_q != StOut) || out_ready;
        end
    end

    assign accept = in_valid && in_ready;
    assign xfer   = out_valid_q && out_ready;

    // Next-state: header decode, extension capture, handoff counting and flush.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        mode1_d  = mode1_q;
        mode2_d  = mode2_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        count_d  = count_q;

        if (xfer) begin
            count_d = count_q + 1'b1;
        end

        unique case (state_q)
            StHdr, StOut: begin
                if (accept) begin
                    // accept in StOut implies out_ready, so the held bundle leaves now
                    opcode_d = in_word[15:8];
                    mode1_d  = in_word[7:6];
                    mode2_d  = in_word[5:4];
                    op1_d    = '0;
                    op2_d    = '0;
                    if (in_word[7:6] != 2'b00) begin
                        state_d = StOp1;
                    end else if (in_word[5:4] != 2'b00) begin
                        state_d = StOp2;
                    end else begin
                        state_d = StOut;
                    end
                end else if (state_q == StOut && xfer) begin
                    state_d = StHdr;
                end
            end
            StOp1: begin
                if (accept) begin
                    op1_d   = in_word;
                    state_d = (mode2_q != 2'b00) ? StOp2 : StOut;
                end
            end
            StOp2: begin
                if (accept) begin
                    op2_d   = in_word;
                    state_d = StOut;
                end
            end
            default: state_d = StHdr;
        endcase

        if (flush) begin
            state_d = StHdr;
        end

        out_valid_d = (state_d == StOut);
    end

    // State and output registers; reset clears everything, including the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StHdr;
            out_valid_q <= 1'b0;
            opcode_q    <= '0;
            mode1_q     <= '0;
            mode2_q     <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            opcode_q    <= opcode_d;
            mode1_q     <= mode1_d;
            mode2_q     <= mode2_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            count_q     <= count_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign opcode      = opcode_q;
    assign mode1       = mode1_q;
    assign mode2       = mode2_q;
    assign op1         = op1_q;
    assign op2         = op2_q;
    assign instr_count = count_q;

endmodule
